// File: rtl/dmp_ctrl_pkg.sv
// Shared types and constants for the domain-control stage.
package dmp_ctrl_pkg;

  // Domain encoding (matches the pmp domain field)
  typedef enum logic [1:0] {
    DOM0 = 2'd0,
    DOM1 = 2'd1,
    DOM2 = 2'd2,
    DOMI = 2'd3
  } dmp_domain_t;

  // dmpcfg CSR layout: lock, reserved, domain
  typedef struct packed {
    logic        l;
    logic [4:0]  rsvd;
    dmp_domain_t dom;
  } dmpcfg_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_COMMIT = 2'd2,
    S_ABORT  = 2'd3
  } dmp_state_e;

  localparam logic [7:0] DMPCFG_RST = 8'h03;

  // Reserved bits are write-ignored and read back as zero
  function automatic logic [7:0] dmpcfg_mask(input logic [7:0] w);
    dmpcfg_t cfg;
    cfg.l    = w[7];
    cfg.rsvd = '0;
    cfg.dom  = dmp_domain_t'(w[1:0]);
    return cfg;
  endfunction

endpackage

// File: rtl/dmp_ctrl_if.sv
// Domain-switch handshake between commit (master) and dmp_ctrl (slave).
interface dmp_ctrl_if;
  import dmp_ctrl_pkg::*;

  logic        switch_valid;
  dmp_domain_t switch_dom;
  logic        switch_ready;
  logic        switch_done;
  logic        switch_err;
  logic        flush;

  modport master (
    output switch_valid, switch_dom,
    input  switch_ready, switch_done, switch_err, flush
  );

  modport slave (
    input  switch_valid, switch_dom,
    output switch_ready, switch_done, switch_err, flush
  );
endinterface

// File: rtl/dmp_cfg_regs.sv
// Lockable dmpcfg CSR array with write masking and read mux.
module dmp_cfg_regs
  import dmp_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1,
  parameter int unsigned IDX_W      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [7:0]              wdata_i,
  output logic [7:0]              rdata_o,
  output logic [NR_ENTRIES*8-1:0] cfg_o
);

  logic [7:0] cfg_q [NR_ENTRIES];

  // Write an unlocked entry; locked entries only clear on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) cfg_q[i] <= DMPCFG_RST;
    end else begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        if (we_i && (idx_i == IDX_W'(i)) && !cfg_q[i][7]) cfg_q[i] <= dmpcfg_mask(wdata_i);
      end
    end
  end

  // Read mux; an index with no matching entry reads zero
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      if (idx_i == IDX_W'(i)) rdata_o = cfg_q[i];
    end
  end

  for (genvar g = 0; g < int'(NR_ENTRIES); g++) begin : g_cfg_out
    assign cfg_o[g*8 +: 8] = cfg_q[g];
  end

endmodule

// File: rtl/dmp_ctrl.sv
// Domain control: current-domain register, dmpcfg CSRs and jitdomain switch FSM.
module dmp_ctrl
  import dmp_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES    = 1,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned IDX_W         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    csr_we_i,
  input  logic [IDX_W-1:0]        csr_idx_i,
  input  logic [7:0]              csr_wdata_i,
  output logic [7:0]              csr_rdata_o,
  input  logic                    lsu_empty_i,
  dmp_ctrl_if.slave               sw,
  output dmp_domain_t             curdom_o,
  output logic [NR_ENTRIES*8-1:0] dmpconf_o
);

  localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);

  dmp_state_e       state_q;
  dmp_domain_t      curdom_q;
  dmp_domain_t      tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             same_dom_c;

  dmp_cfg_regs #(
    .NR_ENTRIES (NR_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_cfg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (csr_we_i),
    .idx_i   (csr_idx_i),
    .wdata_i (csr_wdata_i),
    .rdata_o (csr_rdata_o),
    .cfg_o   (dmpconf_o)
  );

  // Saturating drain-cycle counter increment
  assign cnt_d = (cnt_q == CNT_W'(DRAIN_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

  // Switch FSM: accept in IDLE, wait for LSU drain, then commit or abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      curdom_q <= DOMI;
      tgt_q    <= DOMI;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sw.switch_valid && (sw.switch_dom != curdom_q)) begin
            tgt_q   <= sw.switch_dom;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (lsu_empty_i) begin
            curdom_q <= tgt_q;
            state_q  <= S_COMMIT;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q >= CNT_W'(DRAIN_TIMEOUT - 1)) state_q <= S_ABORT;
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        S_ABORT:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // A switch to the already-current domain completes immediately, without flush
  assign same_dom_c = !rst_i && (state_q == S_IDLE) && sw.switch_valid &&
                      (sw.switch_dom == curdom_q);

  assign sw.switch_ready = (state_q == S_IDLE);
  assign sw.switch_done  = (state_q == S_COMMIT) || same_dom_c;
  assign sw.switch_err   = (state_q == S_ABORT);
  assign sw.flush        = (state_q == S_COMMIT);
  assign curdom_o        = curdom_q;

endmodule
